lcd_spi_arbiter: RTL

//  Shares the single lcd_write SPI byte engine between NUM_REQ requesters (init, char render, future fills).

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_spi_arbiter_rr_pick.sv | 56 +++++
 rtl/lcd_spi_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared constants for the LCD SPI path: word layout of the {dc,byte} words
// handed to lcd_write, arbiter FSM state encodings and watchdog width.
// -----------------------------------------------------------------------------
package lcd_pkg;

  // Word layout: bit 8 selects command (0) or data (1), bits 7:0 carry the byte.
  localparam int LCD_DW = 9;
  localparam int DC_BIT = 8;

  typedef logic [LCD_DW-1:0] lcd_word_t;

  // Watchdog counter width; TIMEOUT must fit in this many bits.
  localparam int WDOG_W = 16;

  // Arbiter FSM encodings, kept as plain constants so legacy code can match them.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;

endpackage : lcd_pkg

// File: rtl/lcd_spi_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational winner selection for lcd_spi_arbiter.
// Requester 0 has fixed top priority. Otherwise the first asserted request at
// or after rr_ptr wins, searching 1..NUM_REQ-1 with wrap-around (0 is never
// part of the rotation).
//
// Ports
//   req         in   NUM_REQ  request vector
//   rr_ptr      in   IW       rotation start point, always in 1..NUM_REQ-1
//   valid       out  1        at least one request present
//   winner_idx  out  IW       index of the winner (0 when !valid)
//   winner      out  NUM_REQ  one-hot winner (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      winner_idx,
  output logic [NUM_REQ-1:0] winner
);

  logic found;
  int   idx;

  // NOTE: every output and temporary gets a default before any branch, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    valid      = |req;
    winner_idx = '0;
    winner     = '0;
    found      = 1'b0;
    idx        = 0;

    if (req[0]) begin
      winner[0] = 1'b1;
      found     = 1'b1;
    end else begin
      // Walk the rotation starting at rr_ptr; the first hit wins.
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        idx = 1 + ((int'(rr_ptr) - 1 + k) % (NUM_REQ - 1));
        for (int i = 1; i < NUM_REQ; i++) begin
          if (!found && (i == idx) && req[i]) begin
            found      = 1'b1;
            winner[i]  = 1'b1;
            winner_idx = IW'(i);
          end
        end
      end
    end
  end

endmodule : rr_pick

// File: rtl/lcd_spi_arbiter.sv
// -----------------------------------------------------------------------------
// lcd_spi_arbiter
// Shares the single lcd_write SPI byte engine between NUM_REQ requesters.
// Requester 0 (lcd_init) has fixed priority, the rest rotate round-robin.
// An owner may hold the bus across several words with lock (burst). A
// watchdog releases an owner that sits in OWN or XFER for TIMEOUT cycles.
//
// Ports
//   sys_clk      in   1            system clock
//   sys_rst_n    in   1            async active-low reset
//   req          in   NUM_REQ      bus request, level
//   lock         in   NUM_REQ      keep ownership after the current word
//   wr_en_in     in   NUM_REQ      1-cycle strobe, data_in[i] valid
//   data_in      in   NUM_REQ*DW   requester i word at [i*DW +: DW]
//   wr_done      in   1            1-cycle pulse from lcd_write, word sent
//   grant        out  NUM_REQ      one-hot owner, registered
//   wr_done_out  out  NUM_REQ      wr_done routed to the owner
//   spi_data     out  DW           word to lcd_write, registered
//   en_write     out  1            1-cycle start pulse to lcd_write
//   busy         out  1            FSM not in IDLE
//   timeout_err  out  1            1-cycle pulse on watchdog release
// -----------------------------------------------------------------------------
module lcd_spi_arbiter
  import lcd_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DW      = LCD_DW,
  parameter int TIMEOUT = 65535
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    lock,
  input  logic [NUM_REQ-1:0]    wr_en_in,
  input  logic [NUM_REQ*DW-1:0] data_in,
  input  logic                  wr_done,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    wr_done_out,
  output logic [DW-1:0]         spi_data,
  output logic                  en_write,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The last cycle count allowed in a state; reaching it forces release.
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  logic [1:0]         state_q,       state_d;
  logic [NUM_REQ-1:0] grant_q,       grant_d;
  logic [NUM_REQ-1:0] wr_done_out_q, wr_done_out_d;
  logic [IW-1:0]      rr_ptr_q,      rr_ptr_d;
  logic [DW-1:0]      spi_data_q,    spi_data_d;
  logic               en_write_q,    en_write_d;
  logic               timeout_err_q, timeout_err_d;
  logic [WDOG_W-1:0]  wdog_q,        wdog_d;

  logic               pick_valid;
  logic [IW-1:0]      pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;

  logic               owner_wr;
  logic               owner_req;
  logic               owner_lock;
  logic [DW-1:0]      owner_word;
  logic               wdog_expired;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .valid      (pick_valid),
    .winner_idx (pick_idx),
    .winner     (pick_onehot)
  );

  // Select the owner's inputs through the one-hot grant; with no owner all
  // of these read as zero.
  always_comb begin
    owner_wr   = 1'b0;
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    owner_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_wr   = wr_en_in[i];
        owner_req  = req[i];
        owner_lock = lock[i];
        owner_word = data_in[i*DW +: DW];
      end
    end
  end

  assign wdog_expired = (wdog_q == WDOG_LAST);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_ptr_d      = rr_ptr_q;
    spi_data_d    = spi_data_q;
    en_write_d    = 1'b0;
    wr_done_out_d = '0;
    timeout_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Owner strobes arriving here are dropped: nobody owns the bus yet.
        if (pick_valid) begin
          state_d = ST_OWN;
          grant_d = pick_onehot;
          if (pick_idx != '0) begin
            rr_ptr_d = (pick_idx == IW'(NUM_REQ - 1)) ? IW'(1) : pick_idx + IW'(1);
          end
        end
      end

      ST_OWN: begin
        if (owner_wr) begin
          spi_data_d = owner_word;
          en_write_d = 1'b1;
          state_d    = ST_XFER;
        end else if (!owner_req) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (wdog_expired) begin
          grant_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_XFER: begin
        // A completion in the same cycle the watchdog expires still counts.
        if (wr_done) begin
          wr_done_out_d = grant_q;
          if (owner_lock) begin
            state_d = ST_OWN;
          end else begin
            grant_d = '0;
            state_d = ST_IDLE;
          end
        end else if (wdog_expired) begin
          grant_d       = '0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog measures time spent in the current OWN/XFER visit only.
    if ((state_q == ST_IDLE) || (state_d != state_q)) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      wr_done_out_q <= '0;
      rr_ptr_q      <= IW'(1);
      spi_data_q    <= '0;
      en_write_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      wdog_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      wr_done_out_q <= wr_done_out_d;
      rr_ptr_q      <= rr_ptr_d;
      spi_data_q    <= spi_data_d;
      en_write_q    <= en_write_d;
      timeout_err_q <= timeout_err_d;
      wdog_q        <= wdog_d;
    end
  end

  assign grant       = grant_q;
  assign wr_done_out = wr_done_out_q;
  assign spi_data    = spi_data_q;
  assign en_write    = en_write_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule : lcd_spi_arbiter
